drive_cmd_scheduler: RTL and testbench

Command scheduler in front of the speed-display/drive datapath. Arbitrates drive commands (instruction, torque) from a manual source and an automatic source into a small FIFO, then releases one command per tick period as a single-cycle `read_enable` strobe with stable `instruction`/`torque`. Also sequences an emergency-stop braking burst. It is the only block that drives `read_enable`, `instruction` and `torque` into the speed display.

---
 rtl/drive_cmd_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_drive_cmd_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_cmd_scheduler.sv
// Round-robin man/auto command arbiter feeding a FIFO; releases one command per tick as a one-cycle strobe, plus an emergency-stop brake burst.
// Define CMD_SCHED_TORQUE_CLAMP_EN to saturate pushed torque 5..7 to 4.
module drive_cmd_scheduler #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ESTOP_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       estop,
    input  logic       man_valid,
    output logic       man_ready,
    input  logic [1:0] man_instr,
    input  logic [2:0] man_torque,
    input  logic       auto_valid,
    output logic       auto_ready,
    input  logic [1:0] auto_instr,
    input  logic [2:0] auto_torque,
    output logic [1:0] instruction,
    output logic [2:0] torque,
    output logic       read_enable,
    output logic       busy
);
    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned EST_W = $clog2(ESTOP_TICKS + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [PTR_W:0]   FULL      = (PTR_W + 1)'(DEPTH);
    localparam logic [EST_W-1:0] EST_LAST  = EST_W'(ESTOP_TICKS - 1);
    localparam logic [EST_W-1:0] EST_DONE  = EST_W'(ESTOP_TICKS);

    typedef enum logic [1:0] {ST_STOP = 2'd0, ST_RUN = 2'd1, ST_ESTOP = 2'd2} state_t;
    typedef struct packed {
        logic [1:0] instr;
        logic [2:0] torque;
    } cmd_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EST_W-1:0] est_q, est_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   fill_q, fill_d;
    logic             last_auto_q, last_auto_d;
    cmd_t             mem_q [DEPTH];
    cmd_t             mem_d [DEPTH];
    logic [1:0]       instr_q, instr_d;
    logic [2:0]       torque_q, torque_d;
    logic             re_q, re_d;
    logic             busy_q, busy_d;

    logic             can_push, grant_man, grant_auto, push, pop, flush, tick_done;
    cmd_t             push_cmd;

    always_comb begin
        can_push   = (state_q != ST_ESTOP) && (fill_q != FULL);
        grant_man  = man_valid && (!auto_valid || last_auto_q);
        grant_auto = auto_valid && (!man_valid || !last_auto_q);
        man_ready  = can_push && grant_man;
        auto_ready = can_push && grant_auto;
        push       = man_ready || auto_ready;
        push_cmd   = man_ready ? cmd_t'({man_instr, man_torque}) : cmd_t'({auto_instr, auto_torque});
`ifdef CMD_SCHED_TORQUE_CLAMP_EN
        if (push_cmd.torque > 3'd4) push_cmd.torque = 3'd4;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        est_d       = est_q;
        instr_d     = instr_q;
        torque_d    = torque_q;
        re_d        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        last_auto_d = last_auto_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        fill_d      = fill_q;
        mem_d       = mem_q;
        tick_done   = (cnt_q == TICK_LAST);

        case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = tick_done ? '0 : cnt_q + 1'b1;
                    if (tick_done) begin
                        re_d = 1'b1;
                        // An empty FIFO still strobes: coast keeps the datapath's speed.
                        if (fill_q != '0) begin
                            pop      = 1'b1;
                            instr_d  = mem_q[rd_q].instr;
                            torque_d = mem_q[rd_q].torque;
                        end else begin
                            instr_d  = 2'b00;
                            torque_d = 3'd0;
                        end
                    end
                end
            end
            ST_ESTOP: begin
                cnt_d = tick_done ? '0 : cnt_q + 1'b1;
                if (est_q != EST_DONE) begin
                    if (tick_done) begin
                        re_d     = 1'b1;
                        instr_d  = 2'b01;
                        torque_d = 3'd4;
                        est_d    = est_q + 1'b1;
                        if (est_q == EST_LAST && !estop) state_d = ST_STOP;
                    end
                end else if (!estop) begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_STOP;
        endcase

        // Entry into ESTOP overrides any strobe or pop decided above.
        if (estop && state_q != ST_ESTOP) begin
            state_d  = ST_ESTOP;
            cnt_d    = '0;
            est_d    = '0;
            flush    = 1'b1;
            re_d     = 1'b0;
            pop      = 1'b0;
            instr_d  = instr_q;
            torque_d = torque_q;
        end

        if (flush) begin
            wr_d   = '0;
            rd_d   = '0;
            fill_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_cmd;
                wr_d        = wr_q + 1'b1;
                last_auto_d = auto_ready;
            end
            if (pop) rd_d = rd_q + 1'b1;
            fill_d = fill_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end

        busy_d = (fill_d != '0) || (state_d == ST_ESTOP);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_STOP;
            cnt_q       <= '0;
            est_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            fill_q      <= '0;
            last_auto_q <= 1'b1;
            instr_q     <= 2'b00;
            torque_q    <= 3'd0;
            re_q        <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            est_q       <= est_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            fill_q      <= fill_d;
            last_auto_q <= last_auto_d;
            instr_q     <= instr_d;
            torque_q    <= torque_d;
            re_q        <= re_d;
            busy_q      <= busy_d;
            mem_q       <= mem_d;
        end
    end

    assign instruction = instr_q;
    assign torque      = torque_q;
    assign read_enable = re_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// Bench for drive_cmd_scheduler: directed scenarios then random traffic, every cycle compared with a queue-based reference model.
module tb_drive_cmd_scheduler;
    localparam int TD    = 4;
    localparam int DEPTH = 4;
    localparam int ET    = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0, enable = 1'b0, estop = 1'b0;
    logic       man_valid = 1'b0, auto_valid = 1'b0;
    logic       man_ready, auto_ready;
    logic [1:0] man_instr = 2'd0, auto_instr = 2'd0;
    logic [2:0] man_torque = 3'd0, auto_torque = 3'd0;
    logic [1:0] instruction;
    logic [2:0] torque;
    logic       read_enable, busy;

    drive_cmd_scheduler #(.TICK_DIV(TD), .DEPTH(DEPTH), .ESTOP_TICKS(ET)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .estop(estop),
        .man_valid(man_valid), .man_ready(man_ready), .man_instr(man_instr), .man_torque(man_torque),
        .auto_valid(auto_valid), .auto_ready(auto_ready), .auto_instr(auto_instr), .auto_torque(auto_torque),
        .instruction(instruction), .torque(torque), .read_enable(read_enable), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=STOP 1=RUN 2=ESTOP, phase = cycles into the tick period.
    int         m_mode = 0, m_phase = 0, m_brakes = 0;
    logic [4:0] m_q[$];
    bit         m_last_auto = 1'b1;
    logic [1:0] e_instr = 2'd0;
    logic [2:0] e_torque = 3'd0;
    logic       e_re = 1'b0, e_busy = 1'b0, e_mr = 1'b0, e_ar = 1'b0;
    logic       pre_mr, pre_ar;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] clamp(input logic [2:0] t);
`ifdef CMD_SCHED_TORQUE_CLAMP_EN
        return (t > 3'd4) ? 3'd4 : t;
`else
        return t;
`endif
    endfunction

    task automatic calc_ready();
        e_mr = 1'b0;
        e_ar = 1'b0;
        if (m_mode != 2 && m_q.size() < DEPTH) begin
            if (man_valid && (!auto_valid || m_last_auto)) e_mr = 1'b1;
            else if (auto_valid) e_ar = 1'b1;
        end
    endtask

    task automatic model_step();
        logic       wrap;
        logic [4:0] pdat;
        e_re = 1'b0;
        if (!reset_n) begin
            m_mode = 0; m_phase = 0; m_brakes = 0; m_q.delete(); m_last_auto = 1'b1;
            e_instr = 2'd0; e_torque = 3'd0; e_busy = 1'b0;
            return;
        end
        if (estop && m_mode != 2) begin
            m_mode = 2; m_phase = 0; m_brakes = 0; m_q.delete();
        end else begin
            wrap = (m_phase == TD - 1);
            pdat = e_mr ? {man_instr, clamp(man_torque)} : {auto_instr, clamp(auto_torque)};
            case (m_mode)
                0: begin m_phase = 0; if (enable) m_mode = 1; end
                1: begin
                    if (!enable) begin
                        m_mode = 0; m_phase = 0;
                    end else begin
                        if (wrap) begin
                            e_re = 1'b1;
                            if (m_q.size() > 0) {e_instr, e_torque} = m_q.pop_front();
                            else begin e_instr = 2'd0; e_torque = 3'd0; end
                        end
                        m_phase = wrap ? 0 : m_phase + 1;
                    end
                end
                default: begin
                    if (m_brakes < ET && wrap) begin
                        e_re = 1'b1; e_instr = 2'b01; e_torque = 3'd4; m_brakes++;
                    end
                    if (m_brakes == ET && !estop) m_mode = 0;
                    m_phase = wrap ? 0 : m_phase + 1;
                end
            endcase
            if (e_mr || e_ar) begin
                m_q.push_back(pdat);
                m_last_auto = e_ar;
            end
        end
        e_busy = (m_q.size() > 0) || (m_mode == 2);
    endtask

    task automatic cyc();
        #2;
        calc_ready();
        pre_mr = man_ready;
        pre_ar = auto_ready;
        chk("man_ready", man_ready, e_mr);
        chk("auto_ready", auto_ready, e_ar);
        @(posedge clk);
        model_step();
        #1;
        chk("read_enable", read_enable, e_re);
        chk("instruction", instruction, e_instr);
        chk("torque", torque, e_torque);
        chk("busy", busy, e_busy);
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin cyc(); n++; end while (read_enable !== 1'b1 && n < 40);
        chk("strobe_seen", read_enable, 1);
    endtask

    initial begin
        int n, strobes, last_idx, gap;

        // Reset state
        repeat (2) begin @(posedge clk); model_step(); end
        #1;
        chk("rst_re", read_enable, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_torque", torque, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mready", man_ready, 0);
        chk("rst_aready", auto_ready, 0);
        reset_n = 1'b1;

        // Single push then RUN: strobe with 00/3, then idle coast tick
        enable = 1'b1; man_valid = 1'b1; man_instr = 2'd0; man_torque = 3'd3;
        cyc();
        man_valid = 1'b0;
        wait_strobe(n);
        chk("first_latency", n, 4);
        chk("first_instr", instruction, 0);
        chk("first_torque", torque, 3);
        wait_strobe(n);
        chk("idle_gap", n, 4);
        chk("idle_torque", torque, 0);

        // Round-robin fill from both sources, then full stall and refill
        reset_n = 1'b0; enable = 1'b0; cyc(); reset_n = 1'b1;
        man_valid = 1'b1; auto_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            man_instr = 2'($urandom); man_torque = 3'($urandom_range(0, 4));
            auto_instr = 2'($urandom); auto_torque = 3'($urandom_range(0, 4));
            cyc();
            chk("rr_man", pre_mr, (k % 2 == 0) && (k < 4));
            chk("rr_auto", pre_ar, (k % 2 == 1) && (k < 4));
        end
        enable = 1'b1;
        n = 0;
        do begin
            cyc(); n++;
            chk("full_stall", pre_mr | pre_ar, 0);
        end while (read_enable !== 1'b1 && n < 40);
        cyc();
        chk("refill", pre_mr | pre_ar, 1);
        cyc();
        chk("refull", pre_mr | pre_ar, 0);
        man_valid = 1'b0; auto_valid = 1'b0;

        // Reset mid-RUN with two entries still queued
        reset_n = 1'b0; enable = 1'b0; cyc(); reset_n = 1'b1;
        man_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            man_instr = 2'd2 + 2'(k); man_torque = 3'd1 + 3'(k);
            cyc();
        end
        man_valid = 1'b0; enable = 1'b1;
        wait_strobe(n);
        chk("pre_rst_instr", instruction, 2);
        cyc();
        reset_n = 1'b0; enable = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("mid_rst_re", read_enable, 0);
        chk("mid_rst_instr", instruction, 0);
        chk("mid_rst_torque", torque, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (10) cyc();

        // Emergency stop with three entries queued
        man_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            man_instr = 2'(k); man_torque = 3'd2; cyc();
        end
        man_valid = 1'b0; estop = 1'b1;
        cyc();
        estop = 1'b0;
        chk("estop_busy", busy, 1);
        strobes = 0; last_idx = 0; gap = 0;
        for (int k = 1; k <= 24; k++) begin
            cyc();
            if (read_enable === 1'b1) begin
                strobes++;
                chk("brake_instr", instruction, 1);
                chk("brake_torque", torque, 4);
                if (strobes == 1) chk("brake_first", k, 4);
                gap = k - last_idx;
                last_idx = k;
            end
        end
        chk("brake_count", strobes, ET);
        chk("brake_gap", gap, 4);
        chk("estop_done_busy", busy, 0);

        // Torque 7 through the FIFO
        enable = 1'b1; man_valid = 1'b1; man_instr = 2'd0; man_torque = 3'd7;
        cyc();
        man_valid = 1'b0;
        wait_strobe(n);
`ifdef CMD_SCHED_TORQUE_CLAMP_EN
        chk("clamp_torque", torque, 4);
`else
        chk("raw_torque", torque, 7);
`endif

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            man_valid   = ($urandom_range(0, 2) != 0);
            auto_valid  = ($urandom_range(0, 2) != 0);
            man_instr   = 2'($urandom); man_torque  = 3'($urandom);
            auto_instr  = 2'($urandom); auto_torque = 3'($urandom);
            enable      = ($urandom_range(0, 15) != 0);
            estop       = ($urandom_range(0, 59) == 0);
            reset_n     = ($urandom_range(0, 149) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
